// File: rtl/ingress_port_bank.sv
// ingress_port_bank: a bank of NUM_PORTS independent word FIFOs.
// The host fills the FIFOs through a small register slave and the scheduler
// drains them through per-channel pop requests.
//
// Handshake, scheduler side: rd_req[p] is a request that is honoured only
// when empty[p] is low on the same edge. The popped word appears on
// rd_data[p] with a single-cycle rd_valid[p] pulse on the following cycle.
// rd_data[p] holds its value until the next pop. There is no backpressure
// on rd_data.
//
// Host side: write/read take effect only when chipselect is high. readdata
// is updated one cycle after a read strobe.
//
// Address map:
//   0      write: bit0 clears all overflow bits, bit1 flushes every channel.
//          read : [22:16] overflow, [14:8] full, [6:0] empty.
//   1..N   write: push the low DATA_W bits of writedata into channel a-1.
//   8+p    read : occupancy count of channel p, zero-extended.
`timescale 1ns/1ps
module ingress_port_bank #(
  parameter int NUM_PORTS = 3,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4096
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        chipselect,
  input  logic                        write,
  input  logic                        read,
  input  logic [3:0]                  address,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  input  logic [NUM_PORTS-1:0]        rd_req,
  output logic [NUM_PORTS*DATA_W-1:0] rd_data,
  output logic [NUM_PORTS-1:0]        rd_valid,
  output logic [NUM_PORTS-1:0]        empty,
  output logic [NUM_PORTS-1:0]        full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Storage is not reset; an emptied channel never exposes stale words
  // because the pointers and counts are cleared.
  logic [DATA_W-1:0] mem [NUM_PORTS][DEPTH];

  logic [PTR_W-1:0] wptr [NUM_PORTS];
  logic [PTR_W-1:0] rptr [NUM_PORTS];
  logic [CNT_W-1:0] cnt [NUM_PORTS];
  logic [CNT_W-1:0] cnt_nxt [NUM_PORTS];

  logic [NUM_PORTS-1:0] overflow;
  logic [NUM_PORTS-1:0] push_sel;
  logic [NUM_PORTS-1:0] push_ok;
  logic [NUM_PORTS-1:0] pop_ok;
  logic [NUM_PORTS-1:0] drop;

  logic        host_wr;
  logic        host_rd;
  logic        ctrl_wr;
  logic        flush;
  logic        clr_ovf;
  logic [31:0] rd_mux;

  // Only the low DATA_W bits of writedata carry payload.
  logic unused_ok;
  assign unused_ok = ^writedata;

  // Decode host strobes and qualify per-channel push and pop.
  // Fullness and emptiness come from the registered flags, so a pop never
  // makes room for a push landing on the same edge.
  always_comb begin
    host_wr = chipselect & write;
    host_rd = chipselect & read;
    ctrl_wr = host_wr && (address == 4'd0);
    flush   = ctrl_wr & writedata[1];
    clr_ovf = ctrl_wr & writedata[0];
    push_sel = '0;
    push_ok  = '0;
    pop_ok   = '0;
    drop     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      push_sel[p] = host_wr && (address == 4'(p + 1));
      push_ok[p]  = push_sel[p] & ~full[p] & ~flush;
      drop[p]     = push_sel[p] & full[p];
      pop_ok[p]   = rd_req[p] & ~empty[p] & ~flush;
      cnt_nxt[p]  = cnt[p] + CNT_W'(push_ok[p]) - CNT_W'(pop_ok[p]);
    end
  end

  // Host read mux: status word at address 0, channel counts at 8+p.
  always_comb begin
    rd_mux = '0;
    if (address == 4'd0) begin
      rd_mux = {9'b0, 7'(overflow), 1'b0, 7'(full), 1'b0, 7'(empty)};
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (address == 4'(8 + p)) begin
        rd_mux = 32'(cnt[p]);
      end
    end
  end

  // Word storage write port.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!reset && push_ok[p]) begin
        mem[p][wptr[p]] <= writedata[DATA_W-1:0];
      end
    end
  end

  // Per-channel pointers, counts, flags and the registered pop output.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (reset || flush) begin
        wptr[p]     <= '0;
        rptr[p]     <= '0;
        cnt[p]      <= '0;
        empty[p]    <= 1'b1;
        full[p]     <= 1'b0;
        rd_valid[p] <= 1'b0;
        if (reset) begin
          rd_data[p*DATA_W +: DATA_W] <= '0;
        end
      end else begin
        rd_valid[p] <= pop_ok[p];
        if (pop_ok[p]) begin
          rd_data[p*DATA_W +: DATA_W] <= mem[p][rptr[p]];
          rptr[p] <= rptr[p] + 1'b1;
        end
        if (push_ok[p]) begin
          wptr[p] <= wptr[p] + 1'b1;
        end
        cnt[p]   <= cnt_nxt[p];
        empty[p] <= (cnt_nxt[p] == '0);
        full[p]  <= (cnt_nxt[p] == CNT_W'(DEPTH));
      end
    end
  end

  // Sticky overflow bits: set on a dropped push, cleared by a control write.
  always_ff @(posedge clk) begin
    if (reset || clr_ovf) begin
      overflow <= '0;
    end else begin
      overflow <= overflow | drop;
    end
  end

  // Registered host read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (host_rd) begin
      readdata <= rd_mux;
    end
  end

endmodule

// File: doc/ingress_port_bank.md
INGRESS_PORT_BANK -- requirements
Module: ingress_port_bank

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 3, number of ingress channels (legal 1..7).
REQ-002 SHALL have parameter DATA_W, default 32, word width (legal 8..32).
REQ-003 SHALL have parameter DEPTH, default 4096, words per channel (power of 2, >=4); CNT_W = log2(DEPTH)+1.
REQ-004 SHALL have one clock and a synchronous, active-high reset, with ports as listed below.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 chipselect  in  1  host slave select.
REQ-008 write  in  1  host write strobe, qualified by chipselect.
REQ-009 read  in  1  host read strobe, qualified by chipselect.
REQ-010 address  in  4  host register/channel select.
REQ-011 writedata  in  32  host write data; low DATA_W bits are payload.
REQ-012 readdata  out  32  host read data, registered.
REQ-013 rd_req  in  NUM_PORTS  per-channel pop request from the scheduler.
REQ-014 rd_data  out  NUM_PORTS*DATA_W  per-channel popped word; channel p occupies bits [p*DATA_W +: DATA_W].
REQ-015 rd_valid  out  NUM_PORTS  per-channel one-cycle pulse qualifying rd_data.
REQ-016 empty  out  NUM_PORTS  per-channel empty flag.
REQ-017 full  out  NUM_PORTS  per-channel full flag.

Function
REQ-018 Host write to address a, 1<=a<=NUM_PORTS, SHALL push writedata[DATA_W-1:0] into channel a-1 on that edge, unless the channel is full.
REQ-019 Write to a full channel SHALL drop the word, leave the pointer unchanged, and set sticky overflow[a-1].
REQ-020 Write to address 0 SHALL act as control: bit0=1 clears all overflow bits; bit1=1 flushes all channels (pointers and counts to 0).
REQ-021 Writes to any other address SHALL be ignored; only one channel is written per cycle.
REQ-022 Each channel SHALL keep a write pointer, a read pointer (both log2(DEPTH) bits, wrapping DEPTH-1 -> 0) and a CNT_W-bit count.
REQ-023 rd_req[p] with empty[p]=0 SHALL pop one word; rd_data for p SHALL be valid with rd_valid[p]=1 on the next cycle (latency 1, synchronous RAM read).
REQ-024 rd_req[p] while empty[p]=1 SHALL be ignored: no pointer change, no rd_valid pulse.
REQ-025 Simultaneous legal push and pop on one channel SHALL both occur with count unchanged; a pop SHALL never free space for a push in the same cycle when the channel is full.
REQ-026 empty[p] = (count==0) and full[p] = (count==DEPTH) SHALL be registered, consistent with the count after each edge.
REQ-027 rd_data[p] SHALL hold its last value while rd_valid[p]=0.
REQ-028 Host read SHALL return data on readdata one cycle after the strobe: address 0 -> {overflow[7:1..], reserved, full, empty} packed as bits[22:16]=overflow, [14:8]=full, [6:0]=empty, unused bits 0.
REQ-029 Host read of address 8+p (p<NUM_PORTS) SHALL return count[p] zero-extended; other addresses SHALL return 0.
REQ-030 A flush coinciding with a push or pop SHALL take priority; that push/pop is discarded and no rd_valid is produced.

Reset
REQ-031 On reset all pointers, counts, overflow bits, rd_valid and readdata SHALL be 0, empty all 1, full all 0; rd_data SHALL be 0.
REQ-032 Reset mid-burst SHALL discard all stored words; RAM contents need not be cleared.
REQ-033 Reset SHALL take priority over every host and scheduler action in the same cycle.

Verification
REQ-034 Write 0xA1,0xA2 to addr 2, then rd_req[1] two cycles -> rd_valid[1] pulses with 0xA1 then 0xA2; empty[1]=1 afterwards.
REQ-035 DEPTH=4: five writes to addr 1 -> full[0]=1 after fourth, fifth dropped, read addr 0 shows bit16=1; write 0x1 to addr 0 clears it.
REQ-036 Channel 0 full, same-cycle push and pop -> push dropped, overflow set, count drops to DEPTH-1.
REQ-037 Channel holding 2 words, same-cycle push and pop -> count stays 2; read addr 8 returns 2.
REQ-038 Wrap: 2*DEPTH+3 push/pop pairs on channel 2 -> data order preserved across pointer wrap.
REQ-039 Reset asserted with 3 words in channel 1 -> next cycle empty=all 1, counts 0, no rd_valid.
